// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the iterative decryptor.
// S-boxes are computed from the field inverse plus the affine map, so no ROM tables live here.
package aes_pkg;

    localparam int NR_AES = 10;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        DEC,
        DONE
    } aes_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128;
        x2   = gmul(a, a);
        x4   = gmul(x2, x2);
        x8   = gmul(x4, x4);
        x16  = gmul(x8, x8);
        x32  = gmul(x16, x16);
        x64  = gmul(x32, x32);
        x128 = gmul(x64, x64);
        return gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [127:0] changeEndian(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless i_last is set. State byte i = row + 4*col sits at bits [8i+7:8i].
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Row r rotates right by r columns on the way back.
    always_comb begin
        w_ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[8*(r+4*c) +: 8] = inv_sbox(i_state[8*(r+4*((c+4-r)%4)) +: 8])
                                        ^ i_rk[8*(r+4*c) +: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = w_ark[32*c      +: 8];
            a1 = w_ark[32*c + 8  +: 8];
            a2 = w_ark[32*c + 16 +: 8];
            a3 = w_ark[32*c + 24 +: 8];
            w_mix[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            w_mix[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            w_mix[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            w_mix[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes_128_dec.sv
// Iterative AES-128 ECB decryptor: 10-cycle forward key expansion (skipped on a key-cache hit), then 10 inverse rounds.
// out_valid at accept+11 (hit) or +21 (miss); result held until out_ready, in_ready only while idle.
module aes_128_dec #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    import aes_pkg::*;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 of a word is in the low bits, so RotWord is a right rotate by one byte.
    function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
        return sub_word({w[7:0], w[31:8]}) ^ {24'h0, rc};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[31:0]   ^ key_g(k[127:96], rc);
        n1 = k[63:32]  ^ n0;
        n2 = k[95:64]  ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[127:96] ^ k[95:64];
        p2 = k[95:64]  ^ k[63:32];
        p1 = k[63:32]  ^ k[31:0];
        p0 = k[31:0]   ^ key_g(p3, rc);
        return {p3, p2, p1, p0};
    endfunction

    aes_state_t   r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_cache_rk;
    logic [127:0] r_cache_key;
    logic         r_cache_vld;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_pt;

    logic [127:0] w_key_le;
    logic [127:0] w_ct_le;
    logic [7:0]   w_rcon;
    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;
    logic [127:0] w_round_out;
    logic         w_hit;

    assign w_key_le  = changeEndian(key);
    assign w_ct_le   = changeEndian(ct);
    assign w_rcon    = rcon(r_cnt);
    assign w_fwd_key = key_fwd(r_key, w_rcon);
    // In DEC r_key holds rk[r+1]; stepping back with rcon[r] yields rk[r].
    assign w_inv_key = key_inv(r_key, w_rcon);
    assign w_hit     = (KEY_CACHE != 0) && r_cache_vld && (key == r_cache_key);

    aes_inv_round u_round (
        .i_state (r_state),
        .i_rk    (w_inv_key),
        .i_last  (r_cnt == 4'd0),
        .o_state (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_cache_rk  <= '0;
            r_cache_key <= '0;
            r_cache_vld <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_pt        <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (w_hit) begin
                            r_state <= w_ct_le ^ r_cache_rk;
                            r_key   <= r_cache_rk;
                            r_cnt   <= 4'(NR_AES - 1);
                            r_fsm   <= DEC;
                        end else begin
                            // Cache is refilled with this key; it only becomes valid once rk10 exists.
                            r_state     <= w_ct_le;
                            r_key       <= w_key_le;
                            r_cnt       <= '0;
                            r_cache_vld <= 1'b0;
                            r_cache_key <= key;
                            r_fsm       <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    r_key <= w_fwd_key;
                    if (r_cnt == 4'(NR_AES - 1)) begin
                        r_cache_rk  <= w_fwd_key;
                        r_cache_vld <= 1'b1;
                        r_state     <= r_state ^ w_fwd_key;
                        r_fsm       <= DEC;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DEC: begin
                    r_state <= w_round_out;
                    r_key   <= w_inv_key;
                    if (r_cnt == 4'd0) begin
                        r_pt        <= changeEndian(w_round_out);
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pt        = r_pt;

endmodule

// File: tb/tb_aes_128_dec.sv
// Scoreboard bench for aes_128_dec: directed FIPS-197 vectors, cache/latency, backpressure, reset, and random round trips.
module tb_aes_128_dec;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] key, ct, pt;
    logic         nc_in_valid, nc_in_ready, nc_out_valid;
    logic [127:0] nc_pt;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   or_mode = 1;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_128_dec #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key), .ct(ct),
        .out_valid(out_valid), .out_ready(out_ready), .pt(pt)
    );

    aes_128_dec #(.KEY_CACHE(0)) dut_nc (
        .clk(clk), .rst(rst), .in_valid(nc_in_valid), .in_ready(nc_in_ready), .key(key), .ct(ct),
        .out_valid(nc_out_valid), .out_ready(1'b1), .pt(nc_pt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] sb_f(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[8*(15-x[3:0]) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    // Reference forward cipher in FIPS byte order (byte 0 = bits [127:120]).
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, t0, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sb_f(tmp[1]) ^ rc;
                tmp[1] = sb_f(tmp[2]);
                tmp[2] = sb_f(tmp[3]);
                tmp[3] = sb_f(t0);
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_f(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Offers one pair starting just after a rising edge; records the accept cycle with the expectation.
    task automatic send(input string name, input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] p, input int lat, output int acc);
        int   guard;
        exp_t e;
        @(posedge clk);
        #1;
        key = k;
        ct = c;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            timeout({name, "_accept"});
            in_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            e.pt = p;
            e.lat = lat;
            e.acc = acc;
            e.name = name;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            timeout({name, "_drain"});
            sb.delete();
        end
    endtask

    task automatic nc_run(input string name);
        int acc, guard;
        @(posedge clk);
        #1;
        key = KA;
        ct = CA;
        nc_in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!nc_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        nc_in_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!nc_out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!nc_out_valid) timeout(name);
        else begin
            chk_int({name, "_lat"}, cyc - acc + 1, 21);
            chk({name, "_pt"}, nc_pt, PA);
        end
    endtask

    initial begin : out_ready_driver
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic prev_ov;
        int   rise;
        exp_t e;
        prev_ov = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (rst) prev_ov = 1'b0;
            else begin
                if (out_valid && !prev_ov) rise = cyc;
                prev_ov = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got pt %h, expected no output", pt);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_pt"}, pt, e.pt);
                        if (e.lat != 0) chk_int({e.name, "_lat"}, rise - e.acc + 1, e.lat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           acc, guard;
        logic [127:0] k, p;
        rst = 1'b1;
        in_valid = 1'b0;
        nc_in_valid = 1'b0;
        key = '0;
        ct = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_pt", pt, '0);
        chk("model_fips_c1", aes_enc(KA, PA), CA);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold cache miss, then hit on the same key; cache-less instance always expands.
        or_mode = 1;
        send("c1_miss", KA, CA, PA, 21, acc);
        drain("c1_miss");
        send("c1_hit", KA, CA, PA, 11, acc);
        drain("c1_hit");
        nc_run("nocache_1");
        nc_run("nocache_2");

        // Key change forces expansion; the cache then holds the new rk10.
        send("b_miss", KB, CB, PB, 21, acc);
        drain("b_miss");
        chk("rk10_cache", bswap(dut.r_cache_rk), RK10B);
        send("b_hit", KB, CB, PB, 11, acc);
        drain("b_hit");

        // Backpressure: result held for 20 cycles while extra offers are ignored.
        or_mode = 0;
        send("bp", KA, CA, PA, 21, acc);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) timeout("bp_valid");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            key = KB;
            ct = 128'hdeadbeef;
            @(negedge clk);
            chk("bp_pt_hold", pt, PA);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        or_mode = 1;
        @(posedge clk);
        #2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        repeat (30) @(negedge clk);
        chk("bp_no_ghost", 128'(out_valid), 128'(0));
        chk_int("bp_sb_empty", sb.size(), 0);

        // Reset in the middle of DEC drops the block and invalidates the cache.
        send("rst_blk", KB, CB, PB, 21, acc);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_pt", pt, '0);
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        send("post_rst_miss", KB, CB, PB, 21, acc);
        drain("post_rst_miss");

        // Random round trips with consumer stalls and occasional key reuse.
        or_mode = 2;
        k = KA;
        for (int i = 0; i < 200; i++) begin
            if (i == 0 || $urandom_range(0, 3) != 0) k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            send("rt", k, aes_enc(k, p), p, 0, acc);
        end
        drain("rt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
